// File: rtl/bank_cmd_arbiter_if.sv
// Bankmachine-side command bundle, timing configuration and PHY-side command
// port of the bank command arbiter.
interface bank_cmd_arbiter_if #(
  parameter int NBANKS = 8,
  parameter int ABITS  = 17
);
  localparam int BW = (NBANKS > 1) ? $clog2(NBANKS) : 1;

  logic [NBANKS-1:0]       bm_cmd_valid;
  logic [NBANKS-1:0]       bm_cmd_ready;
  logic [NBANKS*ABITS-1:0] bm_cmd_a;
  logic [NBANKS-1:0]       bm_cmd_cas;
  logic [NBANKS-1:0]       bm_cmd_ras;
  logic [NBANKS-1:0]       bm_cmd_we;
  logic [NBANKS-1:0]       bm_cmd_is_cmd;
  logic [NBANKS-1:0]       bm_cmd_is_read;
  logic [NBANKS-1:0]       bm_cmd_is_write;

  logic [7:0]              tRRD_cfg;
  logic [7:0]              tFAW_cfg;
  logic [7:0]              tWTR_cfg;
  logic [7:0]              tRTW_cfg;

  logic                    out_valid;
  logic                    out_ready;
  logic [ABITS-1:0]        out_a;
  logic [BW-1:0]           out_ba;
  logic                    out_cas;
  logic                    out_ras;
  logic                    out_we;
  logic                    out_is_cmd;
  logic                    out_is_read;
  logic                    out_is_write;

  modport slave (
    input  bm_cmd_valid, bm_cmd_a, bm_cmd_cas, bm_cmd_ras, bm_cmd_we,
    input  bm_cmd_is_cmd, bm_cmd_is_read, bm_cmd_is_write,
    input  tRRD_cfg, tFAW_cfg, tWTR_cfg, tRTW_cfg,
    input  out_ready,
    output bm_cmd_ready,
    output out_valid, out_a, out_ba, out_cas, out_ras, out_we,
    output out_is_cmd, out_is_read, out_is_write
  );

  modport master (
    output bm_cmd_valid, bm_cmd_a, bm_cmd_cas, bm_cmd_ras, bm_cmd_we,
    output bm_cmd_is_cmd, bm_cmd_is_read, bm_cmd_is_write,
    output tRRD_cfg, tFAW_cfg, tWTR_cfg, tRTW_cfg,
    output out_ready,
    input  bm_cmd_ready,
    input  out_valid, out_a, out_ba, out_cas, out_ras, out_we,
    input  out_is_cmd, out_is_read, out_is_write
  );
endinterface

// File: rtl/bank_cmd_arbiter.sv
// Round-robin arbiter sharing one DRAM command slot among the bankmachines,
// enforcing tRRD/tFAW/tWTR/tRTW and registering the winner toward the PHY.
module bank_cmd_arbiter #(
  parameter int NBANKS = 8,
  parameter int ABITS  = 17
) (
  input logic              sys_clk,
  input logic              sys_rst,
  bank_cmd_arbiter_if.slave bus
);
  localparam int BW = (NBANKS > 1) ? $clog2(NBANKS) : 1;

  // Timers hold the number of further cycles a class stays blocked, so a
  // cfg of N lets the next command go N cycles after the loading transfer.
  function automatic logic [7:0] span(input logic [7:0] cfg);
    return (cfg == 8'd0) ? 8'd0 : cfg - 8'd1;
  endfunction

  function automatic logic [7:0] dec(input logic [7:0] t);
    return (t == 8'd0) ? 8'd0 : t - 8'd1;
  endfunction

  logic [NBANKS-1:0] is_act;
  logic [NBANKS-1:0] elig;
  logic [NBANKS-1:0] ready;
  logic [BW-1:0]     gnt_idx;
  logic [BW-1:0]     cand;
  logic              gnt_any;
  logic              ld;
  logic              xfer;
  logic              faw_full;
  logic [1:0]        faw_free;
  int                scan;

  logic [BW-1:0]     ptr_q, ptr_d;
  logic [7:0]        trrd_q, trrd_d;
  logic [7:0]        wtr_q, wtr_d;
  logic [7:0]        rtw_q, rtw_d;
  logic [7:0]        faw_q [4];
  logic [7:0]        faw_d [4];

  logic              valid_q, valid_d;
  logic [ABITS-1:0]  a_q, a_d;
  logic [BW-1:0]     ba_q, ba_d;
  logic              cas_q, cas_d;
  logic              ras_q, ras_d;
  logic              we_q, we_d;
  logic              is_cmd_q, is_cmd_d;
  logic              is_read_q, is_read_d;
  logic              is_write_q, is_write_d;

  logic [ABITS-1:0]  sel_a;
  logic              sel_cas, sel_ras, sel_we;
  logic              sel_is_cmd, sel_is_read, sel_is_write, sel_act;

  assign faw_full = (faw_q[0] != 8'd0) && (faw_q[1] != 8'd0) &&
                    (faw_q[2] != 8'd0) && (faw_q[3] != 8'd0);

  always_comb begin
    is_act = '0;
    elig   = '0;
    for (int i = 0; i < NBANKS; i++) begin
      is_act[i] = bus.bm_cmd_is_cmd[i] & bus.bm_cmd_ras[i] &
                  ~bus.bm_cmd_cas[i] & ~bus.bm_cmd_we[i];
      elig[i]   = bus.bm_cmd_valid[i] &
                  ~((is_act[i] & ((trrd_q != 8'd0) | faw_full)) |
                    (bus.bm_cmd_is_read[i]  & (wtr_q != 8'd0)) |
                    (bus.bm_cmd_is_write[i] & (rtw_q != 8'd0)));
    end
  end

  // Scan starts one past the last winner and wraps.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    scan    = 0;
    cand    = '0;
    for (int k = 1; k <= NBANKS; k++) begin
      scan = (int'(ptr_q) + k) % NBANKS;
      cand = BW'(scan);
      if (!gnt_any && elig[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign ld   = ~valid_q | bus.out_ready;
  assign xfer = ld & gnt_any;

  always_comb begin
    ready        = '0;
    sel_a        = '0;
    sel_cas      = 1'b0;
    sel_ras      = 1'b0;
    sel_we       = 1'b0;
    sel_is_cmd   = 1'b0;
    sel_is_read  = 1'b0;
    sel_is_write = 1'b0;
    sel_act      = 1'b0;
    for (int i = 0; i < NBANKS; i++) begin
      if (gnt_idx == BW'(i)) begin
        ready[i]     = ld & gnt_any & ~sys_rst;
        sel_a        = bus.bm_cmd_a[i*ABITS +: ABITS];
        sel_cas      = bus.bm_cmd_cas[i];
        sel_ras      = bus.bm_cmd_ras[i];
        sel_we       = bus.bm_cmd_we[i];
        sel_is_cmd   = bus.bm_cmd_is_cmd[i];
        sel_is_read  = bus.bm_cmd_is_read[i];
        sel_is_write = bus.bm_cmd_is_write[i];
        sel_act      = is_act[i];
      end
    end
  end

  assign bus.bm_cmd_ready = ready;

  always_comb begin
    faw_free = 2'd0;
    for (int j = 3; j >= 0; j--) begin
      if (faw_q[j] == 8'd0) faw_free = 2'(j);
    end
  end

  // A load wins over the decrement of the same timer.
  always_comb begin
    trrd_d = dec(trrd_q);
    wtr_d  = dec(wtr_q);
    rtw_d  = dec(rtw_q);
    for (int j = 0; j < 4; j++) faw_d[j] = dec(faw_q[j]);
    if (xfer && sel_act) begin
      trrd_d          = span(bus.tRRD_cfg);
      faw_d[faw_free] = span(bus.tFAW_cfg);
    end
    if (xfer && sel_is_write) wtr_d = span(bus.tWTR_cfg);
    if (xfer && sel_is_read)  rtw_d = span(bus.tRTW_cfg);
  end

  always_comb begin
    ptr_d      = ptr_q;
    valid_d    = valid_q;
    a_d        = a_q;
    ba_d       = ba_q;
    cas_d      = cas_q;
    ras_d      = ras_q;
    we_d       = we_q;
    is_cmd_d   = is_cmd_q;
    is_read_d  = is_read_q;
    is_write_d = is_write_q;
    if (xfer) begin
      ptr_d      = gnt_idx;
      valid_d    = 1'b1;
      a_d        = sel_a;
      ba_d       = gnt_idx;
      cas_d      = sel_cas;
      ras_d      = sel_ras;
      we_d       = sel_we;
      is_cmd_d   = sel_is_cmd;
      is_read_d  = sel_is_read;
      is_write_d = sel_is_write;
    end else if (ld) begin
      valid_d    = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      ptr_q      <= BW'(NBANKS - 1);
      trrd_q     <= 8'd0;
      wtr_q      <= 8'd0;
      rtw_q      <= 8'd0;
      for (int j = 0; j < 4; j++) faw_q[j] <= 8'd0;
      valid_q    <= 1'b0;
      a_q        <= '0;
      ba_q       <= '0;
      cas_q      <= 1'b0;
      ras_q      <= 1'b0;
      we_q       <= 1'b0;
      is_cmd_q   <= 1'b0;
      is_read_q  <= 1'b0;
      is_write_q <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      trrd_q     <= trrd_d;
      wtr_q      <= wtr_d;
      rtw_q      <= rtw_d;
      for (int j = 0; j < 4; j++) faw_q[j] <= faw_d[j];
      valid_q    <= valid_d;
      a_q        <= a_d;
      ba_q       <= ba_d;
      cas_q      <= cas_d;
      ras_q      <= ras_d;
      we_q       <= we_d;
      is_cmd_q   <= is_cmd_d;
      is_read_q  <= is_read_d;
      is_write_q <= is_write_d;
    end
  end

  assign bus.out_valid    = valid_q;
  assign bus.out_a        = a_q;
  assign bus.out_ba       = ba_q;
  assign bus.out_cas      = cas_q;
  assign bus.out_ras      = ras_q;
  assign bus.out_we       = we_q;
  assign bus.out_is_cmd   = is_cmd_q;
  assign bus.out_is_read  = is_read_q;
  assign bus.out_is_write = is_write_q;
endmodule

// File: tb/tb_bank_cmd_arbiter.sv
// Directed bench for bank_cmd_arbiter: a round-robin vector table plus
// hand-written timing, backpressure and async-reset sequences.
module tb_bank_cmd_arbiter;
  localparam int NB = 8;
  localparam int AB = 17;

  typedef enum int {K_NONE, K_PRE, K_ACT, K_RD, K_WR} kind_t;

  typedef struct {
    logic [7:0] valid;
    logic       out_rdy;
    logic [7:0] exp_rdy;
    logic       exp_ov;
    logic [2:0] exp_ba;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bank_cmd_arbiter_if #(.NBANKS(NB), .ABITS(AB)) bus ();
  bank_cmd_arbiter #(.NBANKS(NB), .ABITS(AB)) dut (
    .sys_clk (clk),
    .sys_rst (rst),
    .bus     (bus.slave)
  );

  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;
  int    gt [NB];
  int    chain_src = -1;
  int    chain_dst = 0;
  kind_t chain_kind = K_NONE;
  vec_t  vt [12];

  function automatic logic [AB-1:0] addr_of(input int i);
    return AB'(17'h10000 + i * 17'h0123);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_bank(input int i, input kind_t k);
    bus.bm_cmd_valid[i]    = (k != K_NONE);
    bus.bm_cmd_is_cmd[i]   = (k != K_NONE);
    bus.bm_cmd_ras[i]      = (k == K_PRE) || (k == K_ACT);
    bus.bm_cmd_cas[i]      = (k == K_RD)  || (k == K_WR);
    bus.bm_cmd_we[i]       = (k == K_PRE) || (k == K_WR);
    bus.bm_cmd_is_read[i]  = (k == K_RD);
    bus.bm_cmd_is_write[i] = (k == K_WR);
    bus.bm_cmd_a[i*AB +: AB] = addr_of(i);
  endtask

  // Ready is sampled mid-cycle; the cycle then closes on the rising edge.
  task automatic tick(output logic [7:0] r);
    @(negedge clk);
    r = bus.bm_cmd_ready;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < NB; i++) set_bank(i, K_NONE);
    bus.out_ready = 1'b0;
    bus.tRRD_cfg = 8'd0;
    bus.tFAW_cfg = 8'd0;
    bus.tWTR_cfg = 8'd0;
    bus.tRTW_cfg = 8'd0;
    for (int i = 0; i < NB; i++) gt[i] = -1;
    chain_src = -1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Bankmachine model: drops valid after its transfer; optional chained request.
  task automatic run_cycles(input int n);
    logic [7:0] r;
    int cy;
    for (int c = 0; c < n; c++) begin
      cy = cyc;
      tick(r);
      chk("onehot", 32'($countones(r) <= 1), 32'd1);
      for (int i = 0; i < NB; i++) begin
        if (r[i] && bus.bm_cmd_valid[i]) begin
          gt[i] = cy;
          set_bank(i, K_NONE);
          if (i == chain_src) set_bank(chain_dst, chain_kind);
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r;
    int t0;

    vt[0]  = '{8'h24, 1'b1, 8'h04, 1'b1, 3'd2};
    vt[1]  = '{8'h24, 1'b1, 8'h20, 1'b1, 3'd5};
    vt[2]  = '{8'h24, 1'b1, 8'h04, 1'b1, 3'd2};
    vt[3]  = '{8'h24, 1'b1, 8'h20, 1'b1, 3'd5};
    vt[4]  = '{8'h81, 1'b1, 8'h80, 1'b1, 3'd7};
    vt[5]  = '{8'h81, 1'b1, 8'h01, 1'b1, 3'd0};
    vt[6]  = '{8'h00, 1'b1, 8'h00, 1'b0, 3'd0};
    vt[7]  = '{8'hFF, 1'b0, 8'h02, 1'b1, 3'd1};
    vt[8]  = '{8'hFF, 1'b0, 8'h00, 1'b1, 3'd1};
    vt[9]  = '{8'hFF, 1'b1, 8'h04, 1'b1, 3'd2};
    vt[10] = '{8'h08, 1'b1, 8'h08, 1'b1, 3'd3};
    vt[11] = '{8'h04, 1'b1, 8'h04, 1'b1, 3'd2};

    // Reset state, with a request present so ready must stay gated.
    for (int i = 0; i < NB; i++) set_bank(i, K_NONE);
    set_bank(0, K_PRE);
    bus.out_ready = 1'b1;
    bus.tRRD_cfg = 8'd0;
    bus.tFAW_cfg = 8'd0;
    bus.tWTR_cfg = 8'd0;
    bus.tRTW_cfg = 8'd0;
    #2;
    chk("rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst out_ba", 32'(bus.out_ba), 32'd0);
    chk("rst out_a", 32'(bus.out_a), 32'd0);
    chk("rst ready", 32'(bus.bm_cmd_ready), 32'd0);
    do_reset();

    // Round-robin vector table, all requests PRE.
    for (int v = 0; v < 12; v++) begin
      for (int i = 0; i < NB; i++) set_bank(i, vt[v].valid[i] ? K_PRE : K_NONE);
      bus.out_ready = vt[v].out_rdy;
      tick(r);
      chk($sformatf("vec%0d ready", v), 32'(r), 32'(vt[v].exp_rdy));
      chk($sformatf("vec%0d out_valid", v), 32'(bus.out_valid), 32'(vt[v].exp_ov));
      chk($sformatf("vec%0d out_ba", v), 32'(bus.out_ba), 32'(vt[v].exp_ba));
      chk($sformatf("vec%0d out_a", v), 32'(bus.out_a), 32'(addr_of(int'(vt[v].exp_ba))));
    end
    chk("pre out_ras", 32'(bus.out_ras), 32'd1);
    chk("pre out_we", 32'(bus.out_we), 32'd1);
    chk("pre out_cas", 32'(bus.out_cas), 32'd0);

    // tRRD = 4 between two ACTs.
    do_reset();
    bus.tRRD_cfg = 8'd4;
    bus.out_ready = 1'b1;
    set_bank(0, K_ACT);
    set_bank(1, K_ACT);
    t0 = cyc;
    run_cycles(12);
    chk("trrd first act", 32'(gt[0]), 32'(t0));
    chk("trrd gap", 32'(gt[1] - gt[0]), 32'd4);
    chk("act out_ras", 32'(bus.out_ras), 32'd1);

    // tFAW = 20 with tRRD = 1: four back-to-back, fifth waits for the window.
    do_reset();
    bus.tRRD_cfg = 8'd1;
    bus.tFAW_cfg = 8'd20;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) set_bank(i, K_ACT);
    t0 = cyc;
    run_cycles(30);
    chk("faw act0", 32'(gt[0]), 32'(t0));
    chk("faw act1", 32'(gt[1] - t0), 32'd1);
    chk("faw act2", 32'(gt[2] - t0), 32'd2);
    chk("faw act3", 32'(gt[3] - t0), 32'd3);
    chk("faw act4", 32'(gt[4] - t0), 32'd20);

    // tWTR = 6 then tRTW = 3.
    do_reset();
    bus.tWTR_cfg = 8'd6;
    bus.tRTW_cfg = 8'd3;
    bus.out_ready = 1'b1;
    set_bank(3, K_WR);
    set_bank(4, K_RD);
    chain_src  = 4;
    chain_dst  = 5;
    chain_kind = K_WR;
    t0 = cyc;
    run_cycles(20);
    chk("wtr write", 32'(gt[3]), 32'(t0));
    chk("wtr read gap", 32'(gt[4] - gt[3]), 32'd6);
    chk("rtw write gap", 32'(gt[5] - gt[4]), 32'd3);
    chk("wr out_is_write", 32'(bus.out_is_write), 32'd1);

    // Backpressure: register holds for 5 cycles, then grant on release.
    do_reset();
    set_bank(1, K_PRE);
    set_bank(6, K_PRE);
    bus.out_ready = 1'b1;
    tick(r);
    chk("bp first grant", 32'(r), 32'h02);
    bus.out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick(r);
      chk("bp ready held", 32'(r), 32'd0);
      chk("bp out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp out_ba", 32'(bus.out_ba), 32'd1);
      chk("bp out_a", 32'(bus.out_a), 32'(addr_of(1)));
    end
    bus.out_ready = 1'b1;
    tick(r);
    chk("bp release grant", 32'(r), 32'h40);
    chk("bp release ba", 32'(bus.out_ba), 32'd6);

    // Async reset mid-operation with tRRD counting.
    do_reset();
    bus.tRRD_cfg = 8'd10;
    bus.out_ready = 1'b1;
    set_bank(0, K_ACT);
    tick(r);
    chk("ar act grant", 32'(r), 32'h01);
    set_bank(0, K_NONE);
    bus.out_ready = 1'b0;
    chk("ar pre out_valid", 32'(bus.out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar out_valid", 32'(bus.out_valid), 32'd0);
    chk("ar out_ba", 32'(bus.out_ba), 32'd0);
    set_bank(2, K_ACT);
    #1;
    chk("ar ready in reset", 32'(bus.bm_cmd_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(r);
    chk("ar act after reset", 32'(r), 32'h04);
    chk("ar out_ba after", 32'(bus.out_ba), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bank_cmd_arbiter.md
Name: bank_cmd_arbiter

Overview:
- Shares the single DRAM command slot between the 8 per-bank command streams (bankmachine_0..7 cmd_* ports); one command is granted per cycle, round-robin.
- Enforces inter-bank timing that no single bankmachine can see: tRRD (ACT to ACT), tFAW (four-activate window), tWTR (write to read) and tRTW (read to write).
- The granted command is captured in a one-entry output register and handed to the PHY-side command port with a valid/ready handshake.

Parameters:
NBANKS, 8, number of bankmachine requesters; bank index = ba.
ABITS, 17, width of cmd address field.

Ports:
sys_clk  in  1  clock
sys_rst  in  1  asynchronous active-high reset
bm_cmd_valid  in  NBANKS  per-bank command valid
bm_cmd_ready  out  NBANKS  per-bank accept; transfer when valid&ready
bm_cmd_a  in  NBANKS*ABITS  per-bank address, bank i at [i*ABITS +: ABITS]
bm_cmd_cas, bm_cmd_ras, bm_cmd_we  in  NBANKS each  per-bank command bits
bm_cmd_is_cmd, bm_cmd_is_read, bm_cmd_is_write  in  NBANKS each  per-bank command class
tRRD_cfg, tFAW_cfg, tWTR_cfg, tRTW_cfg  in  8 each  timing in cycles; 0 = no constraint
out_valid  out  1  registered command valid
out_ready  in  1  PHY accepts command
out_a  out  ABITS  registered address
out_ba  out  3  registered bank index
out_cas, out_ras, out_we, out_is_cmd, out_is_read, out_is_write  out  1 each  registered command bits

Behaviour:
- Reset (async, sys_rst=1): out_valid=0, all out_* fields 0, bm_cmd_ready=0, rr pointer=NBANKS-1, all timers 0, FAW slots 0.
- Command classes:
  - ACT = is_cmd & ras & ~cas & ~we.
  - READ = is_read.
  - WRITE = is_write.
  - Anything else (PRE, refresh) is unrestricted.
- Eligibility of bank i: bm_cmd_valid[i] and not blocked.
  - ACT is blocked while trrd_timer != 0 or all 4 FAW slots are nonzero.
  - READ is blocked while wtr_timer != 0.
  - WRITE is blocked while rtw_timer != 0.
- Grant:
  - Scan from pointer+1 upward, wrapping modulo NBANKS; the first eligible bank wins.
  - Combinational within the cycle: no gap cycles between back-to-back grants.
- Load enable: ld = (~out_valid | out_ready).
  - bm_cmd_ready[i] = ld & grant[i]; at most one bit set.
  - bm_cmd_ready is 0 when no bank is eligible.
- On transfer (ld and some grant):
  - The output register captures the bank's fields; out_ba = granted index.
  - out_valid=1 on the next edge.
  - Pointer := granted index.
- When ld and there is no grant, out_valid := 0.
- When out_valid and ~out_ready, the register holds its contents and no grant is made.
- Timers are 8-bit and count in cycles. They load on transfer from the bank, not on PHY acceptance.
  - ACT transfer: trrd_timer := tRRD_cfg; one free FAW slot (the lowest-index zero slot) := tFAW_cfg.
  - WRITE transfer: wtr_timer := tWTR_cfg.
  - READ transfer: rtw_timer := tRTW_cfg.
  - Every nonzero timer/slot not being loaded decrements by 1 each cycle; a load takes priority over the decrement.
  - Net effect: after an ACT accepted in cycle T, the next ACT is eligible no earlier than T+tRRD_cfg (cfg=0 or 1 → T+1). The same rule applies to the other timers.
- The pointer is unchanged when no transfer occurs; fairness holds: a continuously eligible bank is granted within NBANKS transfers.
- Simultaneous READ transfer while wtr_timer is counting is impossible by construction (it is blocked). A timer load in the same cycle as its decrement-to-zero takes the load value.
- Reset mid-operation: everything returns to reset values immediately and asynchronously. A command held in the output register is dropped; the bankmachine side is unaffected because transfers only happen on ready.

Test Plan:
- Banks 2 and 5 hold valid PRE with out_ready=1 → grants alternate 2,5,2,5 on consecutive cycles; out_ba follows one cycle later; no idle cycles.
- tRRD_cfg=4, banks 0 and 1 each present an ACT, out_ready=1 → bank0 ACT accepted at T, bank1 ACT accepted at T+4; bm_cmd_ready[1]=0 during T+1..T+3.
- tRRD_cfg=1, tFAW_cfg=20, ACTs from banks 0..4 → four ACTs at T..T+3, fifth at T+20.
- tWTR_cfg=6: WRITE from bank3 at T, READ pending on bank4 → READ accepted at T+6. Then tRTW_cfg=3: WRITE pending after that read → accepted 3 cycles after it.
- out_ready=0 for 5 cycles with a command in the register → out_* stable, all bm_cmd_ready=0. On out_ready=1 → the next grant is made in that same cycle.
- Assert sys_rst asynchronously between clock edges while out_valid=1 and timers are nonzero → out_valid=0 immediately. After release, with tRRD_cfg=10, an ACT is granted on the first cycle.
